// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
// Turns compact symbolic instruction commands into 32-bit MIPS32 instruction words
// and queues them in a small FIFO for the debug/boot instruction-injection path.
// LI32 expands to LUI followed by ORI, so a two-state command FSM sits in front of the FIFO.
//
// Ports:
//   clock, reset      system clock; synchronous active-high reset
//   flush             synchronous clear of FIFO and FSM (same effect as reset)
//   cmd_valid/ready   command handshake
//   cmd_kind          instruction kind (0..22 legal, 23..31 illegal)
//   cmd_rs/rt/rd      register fields
//   cmd_shamt         shift amount
//   cmd_imm           immediate ([15:0] I-type, [31:0] LI32, [25:0] J target)
//   instr_valid/ready instruction stream handshake
//   instr_word        FIFO head word
//   level             FIFO occupancy
//   err_illegal       one-cycle pulse after an illegal kind is accepted
module mips_instr_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd_kind,
    input  logic [4:0]       cmd_rs,
    input  logic [4:0]       cmd_rt,
    input  logic [4:0]       cmd_rd,
    input  logic [4:0]       cmd_shamt,
    input  logic [31:0]      cmd_imm,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr_word,
    output logic [CNT_W-1:0] level,
    output logic             err_illegal
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {StIdle, StLiLo} state_e;

    function automatic logic [31:0] r_word(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                           logic [4:0] sh, logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_word(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                           logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    state_e           state_q, state_d;
    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] level_q, level_d;
    logic             err_q, err_d;
    logic [4:0]       li_rt_q, li_rt_d;
    logic [15:0]      li_imm_q, li_imm_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        enc_li;
    logic        full, pop, push, accept;
    logic [31:0] push_word;

    // Command encoder; unused fields are tied to zero regardless of inputs.
    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        enc_li    = 1'b0;
        case (cmd_kind)
            5'd0:  enc_word = 32'h0000_0000;
            5'd1:  enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h21);
            5'd2:  enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h23);
            5'd3:  enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h24);
            5'd4:  enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h25);
            5'd5:  enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h26);
            5'd6:  enc_word = r_word(cmd_rs, cmd_rt, cmd_rd, 5'd0, 6'h2A);
            5'd7:  enc_word = r_word(5'd0, cmd_rt, cmd_rd, cmd_shamt, 6'h00);
            5'd8:  enc_word = i_word(6'h09, cmd_rs, cmd_rt, cmd_imm[15:0]);
            5'd9:  enc_word = i_word(6'h0D, cmd_rs, cmd_rt, cmd_imm[15:0]);
            5'd10: enc_word = i_word(6'h0F, 5'd0, cmd_rt, cmd_imm[15:0]);
            5'd11: enc_word = i_word(6'h23, cmd_rs, cmd_rt, cmd_imm[15:0]);
            5'd12: enc_word = i_word(6'h2B, cmd_rs, cmd_rt, cmd_imm[15:0]);
            5'd13: enc_word = i_word(6'h04, cmd_rs, cmd_rt, cmd_imm[15:0]);
            5'd14: enc_word = i_word(6'h05, cmd_rs, cmd_rt, cmd_imm[15:0]);
            5'd15: enc_word = {6'h02, cmd_imm[25:0]};
            5'd16: enc_word = {6'h03, cmd_imm[25:0]};
            5'd17: enc_word = r_word(cmd_rs, 5'd0, 5'd0, 5'd0, 6'h08);
            5'd18: enc_word = {6'h10, 5'h00, cmd_rt, cmd_rd, 11'h000};
            5'd19: enc_word = {6'h10, 5'h04, cmd_rt, cmd_rd, 11'h000};
            5'd20: enc_word = 32'h4200_0018;
            5'd21: begin
                // First half of LI32: LUI rt, imm[31:16]
                enc_word = i_word(6'h0F, 5'd0, cmd_rt, cmd_imm[31:16]);
                enc_li   = 1'b1;
            end
            5'd22: enc_word = 32'h0000_000C;
            default: enc_legal = 1'b0;
        endcase
    end

    assign full      = (level_q == CNT_W'(DEPTH));
    assign pop       = instr_ready && (level_q != '0);
    // No pop-to-ready bypass: readiness depends only on registered state.
    assign cmd_ready = (state_q == StIdle) && !full;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_word = enc_word;
        err_d     = 1'b0;
        li_rt_d   = li_rt_q;
        li_imm_d  = li_imm_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (enc_legal) begin
                        push = 1'b1;
                        if (enc_li) begin
                            li_rt_d  = cmd_rt;
                            li_imm_d = cmd_imm[15:0];
                            state_d  = StLiLo;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLiLo: begin
                push_word = i_word(6'h0D, li_rt_q, li_rt_q, li_imm_q);
                // A pop on the same edge frees the slot the ORI needs.
                if (!full || pop) begin
                    push    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + CNT_W'(1);
            2'b01:   level_d = level_q - CNT_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            err_q    <= 1'b0;
            li_rt_q  <= '0;
            li_imm_q <= '0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            err_q    <= err_d;
            li_rt_q  <= li_rt_d;
            li_imm_q <= li_imm_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage needs no reset; pointers and level define what is valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= push_word;
    end

    assign instr_valid = (level_q != '0);
    assign instr_word  = mem[rd_ptr_q];
    assign level       = level_q;
    assign err_illegal = err_q;

endmodule
